// File: rtl/mpcache_pkg.sv
// Shared FSM type, default geometry and address-split helpers for the
// round-robin multi-port cache.
package mpcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } state_e;

  localparam int DefNumPorts      = 2;
  localparam int DefAddrBusWidth  = 32;
  localparam int DefCacheBusWidth = 32;
  localparam int DefMemBusWidth   = 64;
  localparam int DefLines         = 256;

  function automatic int off_width(input int cache_bus_width);
    return $clog2(cache_bus_width / 8);
  endfunction

  function automatic int wsel_width(input int cache_bus_width, input int mem_bus_width);
    return $clog2(mem_bus_width / cache_bus_width);
  endfunction

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned line_index(input logic [63:0] addr, input int lsb,
                                             input int iw);
    logic [63:0] mask;
    mask = (64'd1 << iw) - 64'd1;
    return 32'((addr >> lsb) & mask);
  endfunction

  function automatic logic [63:0] line_tag(input logic [63:0] addr, input int lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first pending requester at or after the
// pointer, then moves the pointer just past the accepted requester.
module rr_arbiter #(
  parameter  int NumPorts = 2,
  localparam int IdW      = $clog2(NumPorts)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NumPorts-1:0] pending,
  input  logic                accept,
  output logic [NumPorts-1:0] grant,
  output logic [IdW-1:0]      grant_id
);

  logic [IdW-1:0] ptr;
  logic           found;
  int             cand;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < NumPorts; i++) begin
      cand = (int'(ptr) + i) % NumPorts;
      if (!found && pending[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = IdW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      if (int'(grant_id) == NumPorts - 1) ptr <= '0;
      else                                ptr <= grant_id + IdW'(1);
    end
  end

endmodule

// File: rtl/mpcache_rr.sv
// Multi-port direct-mapped write-through cache; one request in flight,
// round-robin port arbitration, line-wide refill, no write-allocate.
//   state      | meaning
//   ST_IDLE    | wait for a pending port, grant and latch its request
//   ST_LOOKUP  | tag compare; pick response, refill or write-through
//   ST_REFILL  | mem_re until mem_ready, fill line on mem_r_data_valid
//   ST_WRITE   | mem_we until mem_ready, patch line on a hit
//   ST_RESP    | pulse port_ready (and read valid) to the granted port
module mpcache_rr
  import mpcache_pkg::*;
#(
  parameter int NumPorts      = DefNumPorts,
  parameter int AddrBusWidth  = DefAddrBusWidth,
  parameter int CacheBusWidth = DefCacheBusWidth,
  parameter int MemBusWidth   = DefMemBusWidth,
  parameter int N             = DefLines
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AddrBusWidth-1:0]    port_addr         [NumPorts],
  input  logic [CacheBusWidth-1:0]   port_w_data       [NumPorts],
  input  logic [NumPorts-1:0]        port_re,
  input  logic [NumPorts-1:0]        port_we,
  output logic [CacheBusWidth-1:0]   port_r_data       [NumPorts],
  output logic [NumPorts-1:0]        port_ready,
  output logic [NumPorts-1:0]        port_r_data_valid,
  output logic [AddrBusWidth-1:0]    mem_addr,
  output logic [MemBusWidth-1:0]     mem_w_data,
  output logic [MemBusWidth/8-1:0]   mem_w_sel,
  output logic                       mem_re,
  output logic                       mem_we,
  input  logic [MemBusWidth-1:0]     mem_r_data,
  input  logic                       mem_ready,
  input  logic                       mem_r_data_valid
);

  localparam int OffW       = off_width(CacheBusWidth);
  localparam int WselW      = wsel_width(CacheBusWidth, MemBusWidth);
  localparam int IdxW       = idx_width(N);
  localparam int LineLsb    = OffW + WselW;
  localparam int TagW       = AddrBusWidth - LineLsb - IdxW;
  localparam int IdW        = $clog2(NumPorts);
  localparam int Ratio      = MemBusWidth / CacheBusWidth;
  localparam int CacheBytes = CacheBusWidth / 8;
  localparam int MemBytes   = MemBusWidth / 8;
  localparam logic [MemBytes-1:0] WordMask = MemBytes'({CacheBytes{1'b1}});

  state_e                          state, state_nxt;
  logic [NumPorts-1:0]             pending, grant;
  logic [IdW-1:0]                  grant_id, gnt_q;
  logic                            accept;
  logic [AddrBusWidth-1:0]         req_addr;
  logic [CacheBusWidth-1:0]        req_wdata;
  logic                            req_write, wr_hit_q, refill_acc;
  logic [CacheBusWidth-1:0]        rsp_data;
  logic [IdxW-1:0]                 req_idx;
  logic [TagW-1:0]                 req_tag;
  logic [WselW-1:0]                req_wsel;
  logic [$clog2(MemBusWidth)-1:0]  word_lsb;
  logic [$clog2(MemBytes)-1:0]     byte_lsb;
  logic                            hit;

  logic [MemBusWidth-1:0]          line_q  [N];
  logic [TagW-1:0]                 tag_q   [N];
  logic [N-1:0]                    valid_q;

  assign pending  = port_re | port_we;
  assign req_idx  = IdxW'(line_index(64'(req_addr), LineLsb, IdxW));
  assign req_tag  = TagW'(line_tag(64'(req_addr), LineLsb + IdxW));
  assign req_wsel = req_addr[OffW +: WselW];
  assign word_lsb = {req_wsel, {(OffW + 3){1'b0}}};
  assign byte_lsb = {req_wsel, {OffW{1'b0}}};
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  rr_arbiter #(.NumPorts(NumPorts)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .pending  (pending),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          accept    = 1'b1;
          state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (req_write) state_nxt = ST_WRITE;
        else if (hit)  state_nxt = ST_RESP;
        else           state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        mem_re = !refill_acc;
        if (mem_r_data_valid) state_nxt = ST_RESP;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (mem_ready) state_nxt = ST_RESP;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= 1'b0;
      wr_hit_q   <= 1'b0;
      refill_acc <= 1'b0;
      rsp_data   <= '0;
      valid_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          refill_acc <= 1'b0;
          if (accept) begin
            gnt_q     <= grant_id;
            req_addr  <= port_addr[grant_id];
            req_wdata <= port_w_data[grant_id];
            req_write <= |(grant & port_we);
          end
        end
        ST_LOOKUP: begin
          wr_hit_q <= hit;
          if (!req_write) rsp_data <= line_q[req_idx][word_lsb +: CacheBusWidth];
        end
        ST_REFILL: begin
          if (mem_ready) refill_acc <= 1'b1;
          if (mem_r_data_valid) begin
            valid_q[req_idx] <= 1'b1;
            rsp_data         <= mem_r_data[word_lsb +: CacheBusWidth];
          end
        end
        default: ;
      endcase
    end
  end

  // Line payload and tags need no reset: valid_q guards every use.
  always_ff @(posedge clk) begin
    if (state == ST_REFILL && mem_r_data_valid) begin
      line_q[req_idx] <= mem_r_data;
      tag_q[req_idx]  <= req_tag;
    end else if (state == ST_WRITE && mem_ready && wr_hit_q) begin
      line_q[req_idx][word_lsb +: CacheBusWidth] <= req_wdata;
    end
  end

  assign mem_addr   = {req_addr[AddrBusWidth-1:LineLsb], {LineLsb{1'b0}}};
  assign mem_w_data = {Ratio{req_wdata}};
  assign mem_w_sel  = (state == ST_WRITE) ? (WordMask << byte_lsb) : '0;

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    assign port_r_data[i]       = rsp_data;
    assign port_ready[i]        = (state == ST_RESP) && (gnt_q == IdW'(i));
    assign port_r_data_valid[i] = (state == ST_RESP) && (gnt_q == IdW'(i)) && !req_write;
  end

endmodule

// File: tb/tb_mpcache_rr.sv
// Bench for mpcache_rr: directed scenarios plus random traffic, checked
// against a reference memory and a line-presence model.
module tb_mpcache_rr;

  logic        clk;
  logic        rst;
  logic [31:0] port_addr   [2];
  logic [31:0] port_w_data [2];
  logic [1:0]  port_re, port_we;
  logic [31:0] port_r_data [2];
  logic [1:0]  port_ready, port_r_data_valid;
  logic [31:0] mem_addr;
  logic [63:0] mem_w_data;
  logic [7:0]  mem_w_sel;
  logic        mem_re, mem_we;
  logic [63:0] mem_r_data;
  logic        mem_ready, mem_r_data_valid;

  logic        rsp_ready, rsp_valid, inj_ready, inj_valid;
  logic [63:0] rsp_data, inj_data;
  bit          stall;

  int          checks, errors;
  int          n_rd, n_wr;
  logic [31:0] last_wr_addr, last_rd_addr;
  logic [7:0]  last_wr_sel;
  logic [63:0] last_wr_data;

  logic [63:0] env_mem [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];
  bit          model_valid [4];
  logic [26:0] model_tag   [4];
  int          last_port;

  assign mem_ready        = rsp_ready | inj_ready;
  assign mem_r_data_valid = rsp_valid | inj_valid;
  assign mem_r_data       = inj_valid ? inj_data : rsp_data;

  mpcache_rr #(
    .NumPorts(2), .AddrBusWidth(32), .CacheBusWidth(32), .MemBusWidth(64), .N(4)
  ) dut (
    .clk(clk), .rst(rst),
    .port_addr(port_addr), .port_w_data(port_w_data),
    .port_re(port_re), .port_we(port_we),
    .port_r_data(port_r_data), .port_ready(port_ready),
    .port_r_data_valid(port_r_data_valid),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_sel(mem_w_sel),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_r_data(mem_r_data), .mem_ready(mem_ready),
    .mem_r_data_valid(mem_r_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_line(input logic [31:0] la);
    return {la ^ 32'h5A5A_0F0F, la + 32'h0102_0304};
  endfunction

  function automatic logic [63:0] env_line(input logic [31:0] la);
    if (env_mem.exists(la)) return env_mem[la];
    return init_line(la);
  endfunction

  function automatic logic [63:0] ref_line(input logic [31:0] la);
    if (ref_mem.exists(la)) return ref_mem[la];
    return init_line(la);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: random accept latency, refill data same cycle or later.
  initial begin : responder
    bit          active, vpend;
    int          wcnt, vdly;
    logic [63:0] line;
    active = 0; vpend = 0; wcnt = 0; vdly = 0;
    rsp_ready = 0; rsp_valid = 0; rsp_data = '0;
    forever begin
      @(negedge clk);
      rsp_ready = 0;
      rsp_valid = 0;
      if (stall || !rst) begin
        active = 0;
        vpend  = 0;
      end else if (vpend) begin
        vdly--;
        if (vdly == 0) begin
          rsp_valid = 1;
          vpend     = 0;
        end
      end else if (mem_re || mem_we) begin
        if (!active) begin
          active = 1;
          wcnt   = $urandom_range(0, 3);
        end
        if (wcnt > 0) begin
          wcnt--;
        end else begin
          active    = 0;
          rsp_ready = 1;
          if (mem_we) begin
            n_wr++;
            last_wr_addr = mem_addr;
            last_wr_sel  = mem_w_sel;
            last_wr_data = mem_w_data;
            line = env_line(mem_addr);
            for (int b = 0; b < 8; b++)
              if (mem_w_sel[b]) line[b*8 +: 8] = mem_w_data[b*8 +: 8];
            env_mem[mem_addr] = line;
          end else begin
            n_rd++;
            last_rd_addr = mem_addr;
            rsp_data     = env_line(mem_addr);
            vdly         = $urandom_range(0, 2);
            if (vdly == 0) rsp_valid = 1;
            else           vpend     = 1;
          end
        end
      end
    end
  end

  task automatic do_req(input int p, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int          cyc, rd0, wr0;
    bit          got, exp_hit;
    logic [31:0] la;
    logic [63:0] line;
    la      = a & 32'hFFFF_FFF8;
    exp_hit = model_valid[a[4:3]] && (model_tag[a[4:3]] == a[31:5]);
    rd0     = n_rd;
    wr0     = n_wr;
    @(negedge clk);
    port_addr[p]   = a;
    port_w_data[p] = wd;
    port_we[p]     = wr;
    port_re[p]     = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      got = port_ready[p];
    end
    chk("ready_timeout", 64'(got), 64'd1);
    if (got) begin
      chk("other_port_quiet", {port_ready[1-p], port_r_data_valid[1-p]}, 0);
      chk("rdata_valid", 64'(port_r_data_valid[p]), 64'(!wr));
    end
    port_re[p] = 0;
    port_we[p] = 0;
    last_port  = p;
    if (wr) begin
      chk("wr_mem_count", n_wr - wr0, 1);
      chk("wr_no_refill", n_rd - rd0, 0);
      chk("wr_mem_addr", last_wr_addr, la);
      chk("wr_mem_sel", last_wr_sel, a[2] ? 8'hF0 : 8'h0F);
      chk("wr_mem_data", last_wr_data, {wd, wd});
      line = ref_line(la);
      if (a[2]) line[63:32] = wd;
      else      line[31:0]  = wd;
      ref_mem[la] = line;
    end else begin
      line = ref_line(la);
      chk("rd_data", port_r_data[p], a[2] ? line[63:32] : line[31:0]);
      chk("rd_refill_count", n_rd - rd0, exp_hit ? 0 : 1);
      if (exp_hit) chk("hit_latency", cyc, 2);
      else         chk("refill_addr", last_rd_addr, la);
      model_valid[a[4:3]] = 1;
      model_tag[a[4:3]]   = a[31:5];
    end
  endtask

  initial begin : main
    int          cyc, p, exp_p, rd0;
    bit          got;
    logic [63:0] line;
    checks = 0; errors = 0; n_rd = 0; n_wr = 0;
    last_wr_addr = '0; last_rd_addr = '0; last_wr_sel = '0; last_wr_data = '0;
    rst = 0; stall = 0;
    inj_ready = 0; inj_valid = 0; inj_data = '0;
    port_re = '0; port_we = '0;
    for (int i = 0; i < 2; i++) begin
      port_addr[i]   = '0;
      port_w_data[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      model_valid[i] = 0;
      model_tag[i]   = '0;
    end
    last_port = 1;
    env_mem[32'h100] = 64'h11112222_33334444;
    ref_mem[32'h100] = 64'h11112222_33334444;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", {mem_re, mem_we}, 0);
    chk("rst_port_ready", {port_ready, port_r_data_valid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_w_sel", mem_w_sel, 0);
    chk("rst_mem_w_data", mem_w_data, 0);
    chk("rst_port_r_data", port_r_data[0], 0);
    rst = 1;
    @(negedge clk);
    chk("idle_after_rst", {port_ready, mem_re, mem_we}, 0);

    // refill then hit in the other half of the line
    do_req(0, 0, 32'h100, 0);
    do_req(0, 0, 32'h104, 0);

    // both ports hold hitting reads: completions must alternate
    @(negedge clk);
    port_addr[0] = 32'h100;
    port_addr[1] = 32'h104;
    port_re      = 2'b11;
    exp_p        = (last_port + 1) % 2;
    rd0          = n_rd;
    line         = ref_line(32'h100);
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      got = 0;
      while (!got && cyc < 10) begin
        @(negedge clk);
        cyc++;
        got = |port_ready;
      end
      chk("rr_timeout", 64'(got), 64'd1);
      p = port_ready[1] ? 1 : 0;
      chk("rr_order", p, exp_p);
      chk("rr_onehot", port_ready, exp_p == 0 ? 2'b01 : 2'b10);
      chk("rr_data", port_r_data[p], p == 0 ? line[31:0] : line[63:32]);
      chk("rr_spacing", cyc, k == 0 ? 2 : 3);
      last_port = p;
      exp_p     = 1 - p;
    end
    port_re = '0;
    chk("rr_no_refill", n_rd - rd0, 0);

    // write hit, read back, write miss without allocate
    do_req(1, 1, 32'h104, 32'hDEADBEEF);
    do_req(0, 0, 32'h104, 0);
    do_req(0, 1, 32'h200, 32'hCAFEF00D);
    do_req(1, 0, 32'h200, 0);

    // reset while a refill is outstanding
    stall = 1;
    rd0   = n_rd;
    @(negedge clk);
    port_addr[0] = 32'h100;
    port_re[0]   = 1;
    cyc = 0;
    while (!mem_re && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_mem_re_seen", 64'(mem_re), 64'd1);
    #2 rst = 0;
    #1 chk("abort_mem_re_drop", {mem_re, mem_we}, 0);
    port_re[0] = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) model_valid[i] = 0;
    last_port = 1;
    @(negedge clk);
    inj_data  = 64'hBAD0BAD0_BAD0BAD0;
    inj_ready = 1;
    inj_valid = 1;
    @(negedge clk);
    inj_ready = 0;
    inj_valid = 0;
    chk("late_resp_ignored", {port_ready, port_r_data_valid, mem_re, mem_we}, 0);
    @(negedge clk);
    chk("late_resp_quiet", {port_ready, port_r_data_valid, mem_re, mem_we}, 0);
    stall = 0;
    chk("abort_no_refill", n_rd - rd0, 0);

    // same-index conflict: three refills
    rd0 = n_rd;
    do_req(0, 0, 32'h100, 0);
    do_req(1, 0, 32'h120, 0);
    do_req(0, 0, 32'h100, 0);
    chk("conflict_refills", n_rd - rd0, 3);

    for (int k = 0; k < 40; k++) begin
      do_req(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             32'($urandom_range(0, 63)) << 2, $urandom);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
